// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

    // Register-file address width (x0..x31)
    localparam int REG_ADDR_W = 5;

    // Width of the flush down-counter; covers FLUSH_CYCLES up to 7
    localparam int FL_W = 3;

    // Bubble instruction loaded by a flushed pipeline register: ADDI x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_MEM_WAIT = 2'd3
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter with asynchronous active-low clear.
module hazard_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Count events, sticking at all-ones instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [REG_ADDR_W-1:0] id_r1_addr,
    input  logic [REG_ADDR_W-1:0] id_r2_addr,
    input  logic                  id_r1_used,
    input  logic                  id_r2_used,
    input  logic                  ex_is_load,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  if_busy,
    input  logic                  mem_busy,
    input  logic                  ex_redirect,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  stall_mem,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // The redirect cycle itself is the first flush cycle
    localparam logic [FL_W-1:0] FL_LOAD = FL_W'(FLUSH_CYCLES - 1);

    hz_state_e       state, state_nx, saved_state, saved_state_nx, cur_state;
    logic [FL_W-1:0] fl_left, fl_left_nx, saved_fl, saved_fl_nx, cur_fl;
    logic            discard, discard_nx;
    logic            pend_redir, pend_redir_nx;
    logic            load_use;
    logic            redir_take;

    // RAW on a load result that MEM-stage forwarding cannot yet supply; x0 never hazards
    assign load_use = ex_is_load && (ex_rd_addr != '0) &&
                      ((id_r1_used && (id_r1_addr == ex_rd_addr)) ||
                       (id_r2_used && (id_r2_addr == ex_rd_addr)));

    // Leaving MEM_WAIT resumes the remembered state in the same cycle
    always_comb begin
        cur_state = state;
        cur_fl    = fl_left;
        if (state == ST_MEM_WAIT) begin
            cur_state = saved_state;
            cur_fl    = saved_fl;
        end
    end

    // Priority-ordered stall/flush decode and next-state logic
    always_comb begin
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        stall_ex       = 1'b0;
        stall_mem      = 1'b0;
        flush_id       = 1'b0;
        flush_ex       = 1'b0;
        redir_take     = 1'b0;
        state_nx       = state;
        fl_left_nx     = fl_left;
        discard_nx     = discard;
        pend_redir_nx  = pend_redir;
        saved_state_nx = saved_state;
        saved_fl_nx    = saved_fl;

        if (!rdy_in) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
        end else if (mem_busy) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            state_nx  = ST_MEM_WAIT;
            if (state != ST_MEM_WAIT) begin
                saved_state_nx = state;
                saved_fl_nx    = fl_left;
            end
            if (ex_redirect) begin
                pend_redir_nx = 1'b1;
            end
        end else if (ex_redirect || pend_redir) begin
            flush_id      = 1'b1;
            flush_ex      = 1'b1;
            redir_take    = 1'b1;
            fl_left_nx    = FL_LOAD;
            discard_nx    = discard | if_busy;
            pend_redir_nx = 1'b0;
            if (FLUSH_CYCLES > 1) begin
                state_nx = ST_FLUSH;
            end else if (discard_nx) begin
                state_nx = ST_DRAIN;
            end else begin
                state_nx = ST_RUN;
            end
        end else begin
            case (cur_state)
                ST_RUN: begin
                    state_nx = ST_RUN;
                    if (load_use) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (if_busy) begin
                        stall_if = 1'b1;
                        flush_id = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    flush_id   = 1'b1;
                    flush_ex   = 1'b1;
                    fl_left_nx = cur_fl - 1'b1;
                    if (cur_fl <= 1) begin
                        state_nx = discard ? ST_DRAIN : ST_RUN;
                    end else begin
                        state_nx = ST_FLUSH;
                    end
                end
                ST_DRAIN: begin
                    stall_if = 1'b1;
                    flush_id = 1'b1;
                    state_nx = ST_DRAIN;
                    if (!if_busy) begin
                        discard_nx = 1'b0;
                        state_nx   = ST_RUN;
                    end
                end
                default: begin
                    state_nx = ST_RUN;
                end
            endcase
        end
    end

    // Sequencer state, flush count and flags
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state       <= ST_RUN;
            fl_left     <= '0;
            discard     <= 1'b0;
            pend_redir  <= 1'b0;
            saved_state <= ST_RUN;
            saved_fl    <= '0;
        end else begin
            state       <= state_nx;
            fl_left     <= fl_left_nx;
            discard     <= discard_nx;
            pend_redir  <= pend_redir_nx;
            saved_state <= saved_state_nx;
            saved_fl    <= saved_fl_nx;
        end
    end

    hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk_in),
        .rst_n (rst_in),
        .inc   (stall_id & rdy_in),
        .count (stall_cnt)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk_in),
        .rst_n (rst_in),
        .inc   (redir_take),
        .count (flush_cnt)
    );

endmodule
